// File: rtl/palette_pkg.sv
// Shared types, fade FSM states and the reset-time palette contents for sprite_palette_bank.
package palette_pkg;

    localparam int unsigned PKG_BANKS   = 4;
    localparam int unsigned PKG_ENTRIES = 16;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic {FadeIdle, FadeRun} fade_state_e;

    localparam rgb_t DEFAULT_PAL [PKG_BANKS][PKG_ENTRIES] = '{
        '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF,
          12'h888, 12'h008, 12'h080, 12'h088, 12'h800, 12'h808, 12'h880, 12'hCCC},
        '{12'h000, 12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666, 12'h777,
          12'h888, 12'h999, 12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD, 12'hEEE, 12'hFFF},
        '{12'h000, 12'hF00, 12'hE10, 12'hD20, 12'hC30, 12'hB40, 12'hA50, 12'h960,
          12'h870, 12'h780, 12'h690, 12'h5A0, 12'h4B0, 12'h3C0, 12'h2D0, 12'h1E0},
        '{12'h000, 12'h00F, 12'h01E, 12'h02D, 12'h03C, 12'h04B, 12'h05A, 12'h069,
          12'h078, 12'h087, 12'h096, 12'h0A5, 12'h0B4, 12'h0C3, 12'h0D2, 12'h0E1}
    };

    // Larger configurations wrap around the stored table.
    function automatic rgb_t default_rgb(input int unsigned bank, input int unsigned idx);
        return DEFAULT_PAL[2'(bank % PKG_BANKS)][4'(idx % PKG_ENTRIES)];
    endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// Fade level sequencer: steps fade_level toward black or full color once per FADE_DIV clocks.
module palette_fade_ctrl
    import palette_pkg::*;
#(
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned FADE_DIV = 4,
    localparam int unsigned DIV_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               fade_start_i,
    input  logic               fade_dir_i,
    output logic [COLOR_W-1:0] fade_level_o,
    output logic               fade_busy_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);

    fade_state_e        state_q;
    logic               dir_q;
    logic               busy_q;
    logic [DIV_W-1:0]   div_q;
    logic [COLOR_W-1:0] level_q;
    logic [COLOR_W-1:0] target;
    logic [COLOR_W-1:0] level_d;

    assign target  = dir_q ? '1 : '0;
    assign level_d = dir_q ? level_q + COLOR_W'(1) : level_q - COLOR_W'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= FadeIdle;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            div_q   <= '0;
            level_q <= '0;
        end else if (fade_start_i) begin
            // Restart also applies mid-fade: keep the level, relatch direction.
            state_q <= FadeRun;
            busy_q  <= 1'b1;
            dir_q   <= fade_dir_i;
            div_q   <= '0;
        end else if (state_q == FadeRun) begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                if (level_q == target) begin
                    state_q <= FadeIdle;
                    busy_q  <= 1'b0;
                end else begin
                    level_q <= level_d;
                    if (level_d == target) begin
                        state_q <= FadeIdle;
                        busy_q  <= 1'b0;
                    end
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign fade_level_o = level_q;
    assign fade_busy_o  = busy_q;

endmodule

// File: rtl/sprite_palette_bank.sv
// Banked sprite palette with a two-stage lookup pipeline and optional global fade.
// Define PALETTE_FADE_EN to build the fade controller and fade arithmetic.
module sprite_palette_bank
    import palette_pkg::*;
#(
    parameter int unsigned IDX_W           = 4,
    parameter int unsigned COLOR_W         = 4,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned TRANSPARENT_IDX = 0,
    parameter int unsigned FADE_DIV        = 4,
    localparam int unsigned BANK_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 pix_valid,
    input  logic [BANK_W-1:0]    bank_sel,
    input  logic [IDX_W-1:0]     index,
    input  logic                 wr_en,
    input  logic [BANK_W-1:0]    wr_bank,
    input  logic [IDX_W-1:0]     wr_index,
    input  logic [3*COLOR_W-1:0] wr_rgb,
    input  logic                 fade_start,
    input  logic                 fade_dir,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 opaque,
    output logic                 out_valid,
    output logic [COLOR_W-1:0]   fade_level,
    output logic                 fade_busy
);

    localparam int unsigned RGB_W   = 3 * COLOR_W;
    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned PROD_W  = 2 * COLOR_W + 1;

    function automatic logic [RGB_W-1:0] reset_entry(input int unsigned b, input int unsigned i);
        rgb_t d;
        d = default_rgb(b, i);
        return {COLOR_W'(d.r), COLOR_W'(d.g), COLOR_W'(d.b)};
    endfunction

    logic [RGB_W-1:0] table_q [NUM_BANKS][ENTRIES];
    logic             rd_in_range;
    logic             wr_in_range;
    logic [RGB_W-1:0] rd_rgb;
    logic             s1_valid_q;
    logic             s1_opaque_q;
    logic [RGB_W-1:0] s1_rgb_q;
    logic [RGB_W-1:0] s2_rgb;
    logic             out_valid_q;
    logic             opaque_q;
    logic [RGB_W-1:0] out_rgb_q;

    assign rd_in_range = 32'(bank_sel) < NUM_BANKS;
    assign wr_in_range = 32'(wr_bank) < NUM_BANKS;
    assign rd_rgb      = rd_in_range ? table_q[bank_sel][index] : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    table_q[b][i] <= reset_entry(b, i);
                end
            end
        end else if (wr_en && wr_in_range) begin
            table_q[wr_bank][wr_index] <= wr_rgb;
        end
    end

`ifdef PALETTE_FADE_EN
    function automatic logic [COLOR_W-1:0] fade_chan(input logic [COLOR_W-1:0] c,
                                                     input logic [COLOR_W-1:0] l);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * PROD_W'(l) + PROD_W'({COLOR_W{1'b1}});
        return c - COLOR_W'(prod >> COLOR_W);
    endfunction

    palette_fade_ctrl #(
        .COLOR_W  (COLOR_W),
        .FADE_DIV (FADE_DIV)
    ) u_fade_ctrl (
        .clk_i        (Clk),
        .reset_i      (Reset),
        .fade_start_i (fade_start),
        .fade_dir_i   (fade_dir),
        .fade_level_o (fade_level),
        .fade_busy_o  (fade_busy)
    );

    always_comb begin
        s2_rgb = '0;
        s2_rgb[3*COLOR_W-1:2*COLOR_W] = fade_chan(s1_rgb_q[3*COLOR_W-1:2*COLOR_W], fade_level);
        s2_rgb[2*COLOR_W-1:COLOR_W]   = fade_chan(s1_rgb_q[2*COLOR_W-1:COLOR_W], fade_level);
        s2_rgb[COLOR_W-1:0]           = fade_chan(s1_rgb_q[COLOR_W-1:0], fade_level);
    end
`else
    logic unused_fade;
    assign unused_fade = ^{fade_start, fade_dir};
    assign fade_level  = '0;
    assign fade_busy   = 1'b0;
    assign s2_rgb      = s1_rgb_q;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s1_opaque_q <= 1'b0;
            s1_rgb_q    <= '0;
            out_valid_q <= 1'b0;
            opaque_q    <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            s1_valid_q  <= pix_valid;
            s1_opaque_q <= index != IDX_W'(TRANSPARENT_IDX);
            s1_rgb_q    <= rd_rgb;
            out_valid_q <= s1_valid_q;
            opaque_q    <= s1_opaque_q;
            out_rgb_q   <= s2_rgb;
        end
    end

    assign out_valid = out_valid_q;
    assign opaque    = opaque_q;
    assign red       = out_rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign green     = out_rgb_q[2*COLOR_W-1:COLOR_W];
    assign blue      = out_rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Self-checking bench for sprite_palette_bank; fade checks follow PALETTE_FADE_EN.
module tb_sprite_palette_bank;
    import palette_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic [1:0]  bank_sel = '0;
    logic [3:0]  index = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [3:0]  wr_index = '0;
    logic [11:0] wr_rgb = '0;
    logic        fade_start = 1'b0;
    logic        fade_dir = 1'b0;
    logic [3:0]  red, green, blue, fade_level;
    logic        opaque, out_valid, fade_busy;

    sprite_palette_bank #(
        .IDX_W           (4),
        .COLOR_W         (4),
        .NUM_BANKS       (4),
        .TRANSPARENT_IDX (0),
        .FADE_DIV        (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .pix_valid  (pix_valid),
        .bank_sel   (bank_sel),
        .index      (index),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_index   (wr_index),
        .wr_rgb     (wr_rgb),
        .fade_start (fade_start),
        .fade_dir   (fade_dir),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .opaque     (opaque),
        .out_valid  (out_valid),
        .fade_level (fade_level),
        .fade_busy  (fade_busy)
    );

    initial forever #5 Clk = ~Clk;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        opq;
    } exp_t;

    typedef struct {
        logic        rd;
        logic [1:0]  b;
        logic [3:0]  i;
        logic        wr;
        logic [1:0]  wb;
        logic [3:0]  wi;
        logic [11:0] wd;
        logic [11:0] er;
        logic        eo;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic rd, input logic [1:0] b, input logic [3:0] i,
                         input logic wr, input logic [1:0] wb, input logic [3:0] wi,
                         input logic [11:0] wd, input logic [11:0] er, input logic eo);
        pix_valid = rd;
        bank_sel  = b;
        index     = i;
        wr_en     = wr;
        wr_bank   = wb;
        wr_index  = wi;
        wr_rgb    = wd;
        if (rd) sb.push_back('{due: cyc + 2, rgb: er, opq: eo});
        @(posedge Clk);
        #1;
        pix_valid = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic lookup(input logic [1:0] b, input logic [3:0] i, input logic [11:0] er,
                          input logic eo);
        drive(1'b1, b, i, 1'b0, 2'd0, 4'd0, 12'h000, er, eo);
    endtask

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    // Output monitor: every cycle either a scoreboard entry is due or out_valid must be low.
    initial forever begin
        exp_t e;
        @(negedge Clk);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("out_valid", out_valid, 1);
            chk("rgb", {red, green, blue}, e.rgb);
            chk("opaque", opaque, e.opq);
        end else begin
            chk("out_valid_idle", out_valid, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  steps;
        bit  seen;
        bit  done;
        logic [3:0] n;

        vecs[0]  = '{1'b1, 2'd0, 4'd3,  1'b0, 2'd0, 4'd0, 12'h000, 12'h0FF, 1'b1};
        vecs[1]  = '{1'b1, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0, 12'h000, 12'h000, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 4'd1,  1'b0, 2'd0, 4'd0, 12'h000, 12'h00F, 1'b1};
        vecs[3]  = '{1'b1, 2'd1, 4'd10, 1'b0, 2'd0, 4'd0, 12'h000, 12'hAAA, 1'b1};
        vecs[4]  = '{1'b1, 2'd3, 4'd15, 1'b0, 2'd0, 4'd0, 12'h000, 12'h0E1, 1'b1};
        vecs[5]  = '{1'b1, 2'd2, 4'd5,  1'b1, 2'd2, 4'd5, 12'hF80, 12'hB40, 1'b1};
        vecs[6]  = '{1'b1, 2'd2, 4'd5,  1'b0, 2'd0, 4'd0, 12'h000, 12'hF80, 1'b1};
        vecs[7]  = '{1'b0, 2'd0, 4'd0,  1'b1, 2'd1, 4'd0, 12'hABC, 12'h000, 1'b0};
        vecs[8]  = '{1'b1, 2'd1, 4'd0,  1'b0, 2'd0, 4'd0, 12'h000, 12'hABC, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0, 12'h000, 12'h000, 1'b0};
        vecs[10] = '{1'b1, 2'd3, 4'd7,  1'b0, 2'd0, 4'd0, 12'h000, 12'h069, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 4'd0,  1'b1, 2'd3, 4'd7, 12'h123, 12'h000, 1'b0};
        vecs[12] = '{1'b1, 2'd3, 4'd7,  1'b0, 2'd0, 4'd0, 12'h000, 12'h123, 1'b1};
        vecs[13] = '{1'b1, 2'd0, 4'd9,  1'b1, 2'd0, 4'd8, 12'h456, 12'h008, 1'b1};
        vecs[14] = '{1'b1, 2'd0, 4'd8,  1'b0, 2'd0, 4'd0, 12'h000, 12'h456, 1'b1};

        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("reset_rgb", {red, green, blue}, 12'h000);
        chk("reset_opaque", opaque, 0);
        chk("reset_level", fade_level, 0);
        chk("reset_busy", fade_busy, 0);
        chk("pkg_default_0_3", DEFAULT_PAL[0][3], 12'h0FF);

        foreach (vecs[k])
            drive(vecs[k].rd, vecs[k].b, vecs[k].i, vecs[k].wr, vecs[k].wb, vecs[k].wi,
                  vecs[k].wd, vecs[k].er, vecs[k].eo);

        for (int i = 0; i < 16; i++) begin
            n = 4'(i);
            lookup(2'd1, n, (i == 0) ? 12'hABC : {n, n, n}, (i == 0) ? 1'b0 : 1'b1);
        end
        repeat (3) @(posedge Clk);
        #1;

        // Reset wins over a same-cycle write and fade start; table reverts to defaults.
        Reset = 1'b1; wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd3; wr_rgb = 12'h999;
        fade_start = 1'b1; fade_dir = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0; wr_en = 1'b0; fade_start = 1'b0;
        chk("rst_prio_busy", fade_busy, 0);
        chk("rst_prio_level", fade_level, 0);
        lookup(2'd2, 4'd5, 12'hB40, 1'b1);
        lookup(2'd0, 4'd3, 12'h0FF, 1'b1);
        lookup(2'd1, 4'd0, 12'h000, 1'b0);
        lookup(2'd0, 4'd8, 12'h888, 1'b1);
        drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 4'd5, 12'hF80, 12'h000, 1'b0);

`ifdef PALETTE_FADE_EN
        fade_dir = 1'b1; fade_start = 1'b1;
        @(posedge Clk);
        #1;
        fade_start = 1'b0;
        chk("start_busy", fade_busy, 1);
        chk("start_level", fade_level, 0);
        steps = 0; seen = 0; done = 0;
        for (int k = 1; k <= 200 && !done; k++) begin
            @(posedge Clk);
            #1;
            pix_valid = 1'b0;
            if (fade_level == 4'd8 && !seen) begin
                seen = 1;
                pix_valid = 1'b1; bank_sel = 2'd2; index = 4'd5;
                sb.push_back('{due: cyc + 2, rgb: 12'h740, opq: 1'b1});
            end
            if (fade_level == 4'd15) begin
                done = 1;
                steps = k;
            end
        end
        pix_valid = 1'b0;
        chk("saw_level8", seen, 1);
        chk("fade_cycles", steps, 60);
        chk("fade_done_busy", fade_busy, 0);
        chk("fade_done_level", fade_level, 15);
        lookup(2'd2, 4'd5, 12'h000, 1'b1);

        // Already at target: one divider period busy, no level change.
        fade_dir = 1'b1; fade_start = 1'b1;
        @(posedge Clk);
        #1;
        fade_start = 1'b0;
        chk("at_target_busy", fade_busy, 1);
        repeat (3) @(posedge Clk);
        #1;
        chk("at_target_hold", fade_busy, 1);
        @(posedge Clk);
        #1;
        chk("at_target_idle", fade_busy, 0);
        chk("at_target_level", fade_level, 15);

        // Restart mid-fade relatches direction and clears the divider.
        fade_dir = 1'b0; fade_start = 1'b1;
        @(posedge Clk);
        #1;
        fade_start = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        chk("down_level", fade_level, 13);
        fade_dir = 1'b1; fade_start = 1'b1;
        @(posedge Clk);
        #1;
        fade_start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("relatch_div_clear", fade_level, 13);
        @(posedge Clk);
        #1;
        chk("relatch_up", fade_level, 14);
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(posedge Clk);
            #1;
            if (!fade_busy) done = 1;
        end
        chk("relatch_finish", done, 1);
        chk("relatch_final_level", fade_level, 15);

        // Reset mid-fade aborts it and drops an in-flight lookup.
        fade_dir = 1'b0; fade_start = 1'b1;
        @(posedge Clk);
        #1;
        fade_start = 1'b0;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge Clk);
            #1;
            if (fade_level == 4'd6) seen = 1;
        end
        chk("reach_level6", seen, 1);
        pix_valid = 1'b1; bank_sel = 2'd2; index = 4'd5;
        @(posedge Clk);
        #1;
        pix_valid = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("abort_level", fade_level, 0);
        chk("abort_busy", fade_busy, 0);
        chk("abort_valid", out_valid, 0);
        repeat (6) @(posedge Clk);
        #1;
        chk("abort_stays_idle", fade_busy, 0);
`else
        fade_dir = 1'b1; fade_start = 1'b1;
        @(posedge Clk);
        #1;
        fade_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("nofade_busy", fade_busy, 0);
            chk("nofade_level", fade_level, 0);
            @(posedge Clk);
            #1;
        end
        lookup(2'd2, 4'd5, 12'hF80, 1'b1);
        lookup(2'd2, 4'd0, 12'h000, 1'b0);
`endif

        repeat (4) @(posedge Clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
